ahb_slave_interface: RTL
========================

Name: ahb_slave_interface

Overview:
AHB-side front end of the AHB-to-APB bridge. It sits directly upstream of the APB FSM controller.
- Qualifies AHB transfers, decodes the target APB slave, and pipelines address, write data and direction.
- Produces the controller inputs: valid, haddr1/haddr2, hwdata1/hwdata2, hwritereg, tempsel.
- Returns prdata to the AHB master and generates the two-cycle AHB ERROR response for unmapped addresses.

Parameters:
- SLV0_BASE, 32'h8000_0000, base of APB slave 0 window
- SLV1_BASE, 32'h8400_0000, base of APB slave 1 window
- SLV2_BASE, 32'h8800_0000, base of APB slave 2 window
- WIN_SIZE, 32'h0400_0000, size of each window (power of two)

Ports:
- clk  in  1  bridge clock
- hresetn  in  1  asynchronous active-low reset
- hsel  in  1  bridge selected by AHB decoder
- hreadyin  in  1  system HREADY
- hwrite  in  1  AHB direction, 1 = write
- htrans  in  2  AHB transfer type
- haddr  in  32  AHB address
- hwdata  in  32  AHB write data
- prdata  in  32  APB read data
- valid  out  1  qualified mapped transfer (combinational)
- haddr1  out  32  address, 1 pipeline stage
- haddr2  out  32  address, 2 pipeline stages
- hwdata1  out  32  write data, 1 stage
- hwdata2  out  32  write data, 2 stages
- hwritereg  out  1  registered hwrite
- tempsel  out  3  one-hot APB slave select (combinational)
- hrdata  out  32  read data to AHB
- hresp  out  1  0 = OKAY, 1 = ERROR
- err_hready  out  1  low during first ERROR cycle; ANDed into system HREADY

Behaviour:
- Reset values: haddr1, haddr2, hwdata1, hwdata2 = 0; hwritereg = 0; hresp = 0; err_hready = 1; error FSM in ERR_IDLE.
- active = hsel & hreadyin & (htrans == NONSEQ 2'b10 | htrans == SEQ 2'b11). IDLE 2'b00 and BUSY 2'b01 are never active.
- mapped = haddr falls in [SLVn_BASE, SLVn_BASE+WIN_SIZE) for some n.
- valid = active & mapped & (error FSM in ERR_IDLE or ERR_2).
- tempsel = 3'b001 / 3'b010 / 3'b100 for slave 0 / 1 / 2; 3'b000 if unmapped.
- Pipeline registers update on posedge clk only when hreadyin = 1; they hold otherwise:
  - haddr1 <= haddr; haddr2 <= haddr1
  - hwdata1 <= hwdata; hwdata2 <= hwdata1
  - hwritereg <= hwrite
- hrdata = prdata, combinational pass-through, zero added latency.
- Error FSM, encoded in a 2-bit enum:
  - ERR_IDLE: if active & ~mapped, go to ERR_1; else stay.
  - ERR_1: hresp = 1, err_hready = 0; always go to ERR_2.
  - ERR_2: hresp = 1, err_hready = 1. If active & ~mapped, go to ERR_1; else go to ERR_IDLE.
  - All other states drive hresp = 0, err_hready = 1 (registered outputs).
- An unmapped transfer never asserts valid and never disturbs haddr2/hwdata2 alignment beyond its normal shift.
- A simultaneous mapped transfer in ERR_2 is accepted normally (valid = 1).
- Reset asserted mid-operation: all registers clear immediately and asynchronously; the FSM returns to ERR_IDLE.
- Address-window boundary: SLV2_BASE+WIN_SIZE-1 is mapped; SLV2_BASE+WIN_SIZE is unmapped.

Optional Feature:
Macro ADDR_ERR_EN.
- Defined: error FSM present as described above.
- Undefined: no error FSM. hresp tied to 0 and err_hready tied to 1. Unmapped transfers are silently dropped (valid = 0) with an OKAY response. Ports are unchanged in both builds.

Decomposition:
- Shared package ahb2apb_pkg holds:
  - htrans_t enum (IDLE, BUSY, NONSEQ, SEQ)
  - err_state_t enum
  - HRESP_OKAY / HRESP_ERROR constants
  - default slave base and window-size constants
- One natural sub-module: ahb_addr_decoder. It is purely combinational, takes haddr, and returns tempsel and mapped. The FSM controller's tempsel source can reuse it.

Test Plan:
- Reset: hresetn = 0 with random inputs -> all registered outputs 0, err_hready = 1, hresp = 0; after release with htrans = IDLE, valid = 0.
- Single write: hsel = 1, htrans = 2'b10, hwrite = 1, haddr = 32'h8400_0010, then hwdata = 32'hDEAD_BEEF -> valid = 1 in the address cycle with tempsel = 3'b010; next edge haddr1 = 32'h8400_0010, hwritereg = 1; following edge hwdata1 = 32'hDEAD_BEEF, haddr2 = 32'h8400_0010.
- Wait state: hreadyin = 0 for 3 cycles after a NONSEQ to 32'h8000_0004 -> haddr1/haddr2/hwritereg frozen; valid = 0 throughout.
- Unmapped (ADDR_ERR_EN defined): NONSEQ to 32'h8C00_0000 -> valid = 0, tempsel = 0; next cycle hresp = 1, err_hready = 0; following cycle hresp = 1, err_hready = 1; then hresp = 0.
- Back-to-back error then good: second NONSEQ to 32'h8800_0000 issued in ERR_2 -> valid = 1, tempsel = 3'b100; FSM goes to ERR_IDLE.
- BUSY/IDLE filtering and read-data path: htrans = 2'b01 to 32'h8000_0000 -> valid = 0; prdata = 32'h1234_5678 -> hrdata = 32'h1234_5678 in the same cycle.

Source files
------------

// File: rtl/ahb2apb_pkg.sv
// Shared types and constants for the AHB-to-APB bridge: transfer types, the
// address-error FSM states, response codes and default APB slave windows.
package ahb2apb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        ERR_IDLE = 2'b00,
        ERR_1    = 2'b01,
        ERR_2    = 2'b10
    } err_state_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int          NUM_SLV       = 3;
    localparam logic [31:0] SLV0_BASE_DEF = 32'h8000_0000;
    localparam logic [31:0] SLV1_BASE_DEF = 32'h8400_0000;
    localparam logic [31:0] SLV2_BASE_DEF = 32'h8800_0000;
    localparam logic [31:0] WIN_SIZE_DEF  = 32'h0400_0000;

    // Checking addr >= base first guarantees the offset subtraction cannot wrap.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        logic [31:0] offset;
        offset = addr - base;
        return (addr >= base) && (offset < size);
    endfunction

endpackage

// File: rtl/ahb_addr_decoder.sv
// Combinational APB slave decoder: one-hot slave select plus a mapped flag.
// Shared by the AHB slave interface and the APB FSM controller.
module ahb_addr_decoder
    import ahb2apb_pkg::*;
#(
    parameter logic [31:0] SLV0_BASE = SLV0_BASE_DEF,
    parameter logic [31:0] SLV1_BASE = SLV1_BASE_DEF,
    parameter logic [31:0] SLV2_BASE = SLV2_BASE_DEF,
    parameter logic [31:0] WIN_SIZE  = WIN_SIZE_DEF
) (
    input  logic [31:0]        haddr,
    output logic [NUM_SLV-1:0] tempsel,
    output logic               mapped
);

    localparam logic [NUM_SLV-1:0][31:0] BASES = {SLV2_BASE, SLV1_BASE, SLV0_BASE};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLV; gi++) begin : g_slv
            assign tempsel[gi] = in_window(haddr, BASES[gi], WIN_SIZE);
        end
    endgenerate

    assign mapped = |tempsel;

endmodule

// File: rtl/ahb_slave_interface.sv
// AHB front end of the AHB-to-APB bridge: qualifies and pipelines transfers.
// Define ADDR_ERR_EN to build the two-cycle ERROR response for unmapped addresses.
module ahb_slave_interface
    import ahb2apb_pkg::*;
#(
    parameter logic [31:0] SLV0_BASE = SLV0_BASE_DEF,
    parameter logic [31:0] SLV1_BASE = SLV1_BASE_DEF,
    parameter logic [31:0] SLV2_BASE = SLV2_BASE_DEF,
    parameter logic [31:0] WIN_SIZE  = WIN_SIZE_DEF
) (
    input  logic        clk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic        hreadyin,
    input  logic        hwrite,
    input  logic [1:0]  htrans,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    input  logic [31:0] prdata,
    output logic        valid,
    output logic [31:0] haddr1,
    output logic [31:0] haddr2,
    output logic [31:0] hwdata1,
    output logic [31:0] hwdata2,
    output logic        hwritereg,
    output logic [2:0]  tempsel,
    output logic [31:0] hrdata,
    output logic        hresp,
    output logic        err_hready
);

    logic        active;
    logic        mapped;
    logic        err_accept;
    logic [31:0] haddr1_reg;
    logic [31:0] haddr2_reg;
    logic [31:0] hwdata1_reg;
    logic [31:0] hwdata2_reg;
    logic        hwrite_reg;

    ahb_addr_decoder #(
        .SLV0_BASE (SLV0_BASE),
        .SLV1_BASE (SLV1_BASE),
        .SLV2_BASE (SLV2_BASE),
        .WIN_SIZE  (WIN_SIZE)
    ) u_decoder (
        .haddr   (haddr),
        .tempsel (tempsel),
        .mapped  (mapped)
    );

    assign active = hsel && hreadyin &&
                    ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    assign valid  = active && mapped && err_accept;
    assign hrdata = prdata;

    always_ff @(posedge clk or negedge hresetn) begin
        if (!hresetn) begin
            haddr1_reg  <= '0;
            haddr2_reg  <= '0;
            hwdata1_reg <= '0;
            hwdata2_reg <= '0;
            hwrite_reg  <= 1'b0;
        end else if (hreadyin) begin
            haddr1_reg  <= haddr;
            haddr2_reg  <= haddr1_reg;
            hwdata1_reg <= hwdata;
            hwdata2_reg <= hwdata1_reg;
            hwrite_reg  <= hwrite;
        end
    end

    assign haddr1    = haddr1_reg;
    assign haddr2    = haddr2_reg;
    assign hwdata1   = hwdata1_reg;
    assign hwdata2   = hwdata2_reg;
    assign hwritereg = hwrite_reg;

`ifdef ADDR_ERR_EN
    err_state_t err_state_reg;
    err_state_t err_state_next;
    logic       hresp_reg;
    logic       err_hready_reg;

    always_ff @(posedge clk or negedge hresetn) begin
        if (!hresetn) begin
            err_state_reg  <= ERR_IDLE;
            hresp_reg      <= HRESP_OKAY;
            err_hready_reg <= 1'b1;
        end else begin
            err_state_reg  <= err_state_next;
            hresp_reg      <= (err_state_next == ERR_1 || err_state_next == ERR_2) ?
                              HRESP_ERROR : HRESP_OKAY;
            err_hready_reg <= (err_state_next != ERR_1);
        end
    end

    always_comb begin
        err_state_next = err_state_reg;
        case (err_state_reg)
            ERR_IDLE: if (active && !mapped) err_state_next = ERR_1;
            ERR_1:    err_state_next = ERR_2;
            ERR_2:    err_state_next = (active && !mapped) ? ERR_1 : ERR_IDLE;
            default:  err_state_next = ERR_IDLE;
        endcase
    end

    // Mapped transfers are still accepted during the second ERROR cycle.
    assign err_accept = (err_state_reg == ERR_IDLE) || (err_state_reg == ERR_2);
    assign hresp      = hresp_reg;
    assign err_hready = err_hready_reg;
`else
    assign err_accept = 1'b1;
    assign hresp      = HRESP_OKAY;
    assign err_hready = 1'b1;
`endif

endmodule
